// File: rtl/l1_addr_decode_pipe.sv
// l1_addr_decode_pipe: buffered L1 address decoder.
// Sits between the request arbiter and the tag/data SRAM lookup stage.
//
// Each accepted request is split into tag, set index and in-block offset.
// The address arrives either as a full byte address or as a block address.
// The set index can optionally be XOR-hashed with the low tag bits.
// Every entry carries a flag that says whether its set matches the set of
// the previously accepted request.
// Decoded requests sit in a 2-entry skid buffer, so in_ready_o and all
// out_* ports are driven straight from flops.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   flush_i        synchronous clear of the buffer and the set history
//   in_valid_i     request valid          in_ready_o   buffer can accept
//   addr_i         address (block address in [BA_BITS-1:0] when addr_is_ba_i=1)
//   addr_is_ba_i   1: addr_i carries a block address
//   out_valid_o    decoded request valid  out_ready_i  consumer accepts
//   tag_o, set_o, off_o, same_set_o   fields of the head entry

module l1_addr_decode_pipe #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned SETIDXBITS       = 5,
  parameter int unsigned BLOCK_OFFSETBITS = 1,
  parameter int unsigned WORD_OFFSETBITS  = 1,
  parameter int unsigned SET_HASH         = 0,
  localparam int unsigned OFFBITS = BLOCK_OFFSETBITS + WORD_OFFSETBITS,
  localparam int unsigned BA_BITS = XLEN - OFFBITS,
  localparam int unsigned TAGBITS = BA_BITS - SETIDXBITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [XLEN-1:0]       addr_i,
  input  logic                  addr_is_ba_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TAGBITS-1:0]    tag_o,
  output logic [SETIDXBITS-1:0] set_o,
  output logic [OFFBITS-1:0]    off_o,
  output logic                  same_set_o
);

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;

  // The hash folds tag[SETIDXBITS-1:0] into the set, so the tag must be at least that wide.
  if (SET_HASH != 0 && TAGBITS < SETIDXBITS) begin : g_bad_cfg
    $error("l1_addr_decode_pipe: TAGBITS < SETIDXBITS is illegal with SET_HASH=1");
  end

  // Push-side decode.
  logic [TAGBITS-1:0]    raw_tag;
  logic [SETIDXBITS-1:0] raw_set;
  logic [OFFBITS-1:0]    raw_off;
  logic [SETIDXBITS-1:0] hash_set;
  logic                  new_same;

  always_comb begin
    raw_tag = '0;
    raw_set = '0;
    raw_off = '0;
    if (addr_is_ba_i) begin
      raw_set = addr_i[SETIDXBITS-1:0];
      raw_tag = addr_i[BA_BITS-1:SETIDXBITS];
    end else begin
      raw_off = addr_i[OFFBITS-1:0];
      raw_set = addr_i[OFFBITS+SETIDXBITS-1:OFFBITS];
      raw_tag = addr_i[XLEN-1:OFFBITS+SETIDXBITS];
    end
  end

  if (SET_HASH != 0) begin : g_hash
    assign hash_set = raw_set ^ raw_tag[SETIDXBITS-1:0];
  end else begin : g_direct
    assign hash_set = raw_set;
  end

  // Set of the most recently accepted request.
  logic                  hist_valid;
  logic [SETIDXBITS-1:0] hist_set;

  assign new_same = hist_valid & (hash_set == hist_set);

  // Buffer storage and its control state.
  logic [TAGBITS-1:0]    mem_tag  [DEPTH];
  logic [SETIDXBITS-1:0] mem_set  [DEPTH];
  logic [OFFBITS-1:0]    mem_off  [DEPTH];
  logic                  mem_same [DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [TAGBITS-1:0]    mem_tag_n  [DEPTH];
  logic [SETIDXBITS-1:0] mem_set_n  [DEPTH];
  logic [OFFBITS-1:0]    mem_off_n  [DEPTH];
  logic                  mem_same_n [DEPTH];
  logic                  wr_ptr_n;
  logic                  rd_ptr_n;
  logic [CNT_W-1:0]      count_n;
  logic [TAGBITS-1:0]    tag_n;
  logic [SETIDXBITS-1:0] set_n;
  logic [OFFBITS-1:0]    off_n;
  logic                  same_n;
  logic                  push;
  logic                  pop;

  // Next buffer state, plus the head entry that will drive the outputs after the edge.
  always_comb begin
    push       = in_valid_i & in_ready_o & ~flush_i;
    pop        = out_valid_o & out_ready_i & ~flush_i;
    mem_tag_n  = mem_tag;
    mem_set_n  = mem_set;
    mem_off_n  = mem_off;
    mem_same_n = mem_same;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    count_n    = count + CNT_W'(push) - CNT_W'(pop);
    tag_n      = '0;
    set_n      = '0;
    off_n      = '0;
    same_n     = 1'b0;

    if (push) begin
      mem_tag_n[wr_ptr]  = raw_tag;
      mem_set_n[wr_ptr]  = hash_set;
      mem_off_n[wr_ptr]  = raw_off;
      mem_same_n[wr_ptr] = new_same;
      wr_ptr_n           = ~wr_ptr;
    end
    if (pop) begin
      rd_ptr_n = ~rd_ptr;
    end
    if (flush_i) begin
      wr_ptr_n = 1'b0;
      rd_ptr_n = 1'b0;
      count_n  = '0;
    end

    if (count_n != '0) begin
      tag_n  = mem_tag_n[rd_ptr_n];
      set_n  = mem_set_n[rd_ptr_n];
      off_n  = mem_off_n[rd_ptr_n];
      same_n = mem_same_n[rd_ptr_n];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_tag[i]  <= '0;
        mem_set[i]  <= '0;
        mem_off[i]  <= '0;
        mem_same[i] <= 1'b0;
      end
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      hist_valid  <= 1'b0;
      hist_set    <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      tag_o       <= '0;
      set_o       <= '0;
      off_o       <= '0;
      same_set_o  <= 1'b0;
    end else begin
      mem_tag     <= mem_tag_n;
      mem_set     <= mem_set_n;
      mem_off     <= mem_off_n;
      mem_same    <= mem_same_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      in_ready_o  <= (count_n != CNT_W'(DEPTH));
      out_valid_o <= (count_n != '0);
      tag_o       <= tag_n;
      set_o       <= set_n;
      off_o       <= off_n;
      same_set_o  <= same_n;
      if (flush_i) begin
        hist_valid <= 1'b0;
      end else if (push) begin
        hist_valid <= 1'b1;
        hist_set   <= hash_set;
      end
    end
  end

endmodule

// File: tb/tb_l1_addr_decode_pipe.sv
// Testbench for l1_addr_decode_pipe: a direct-index and a hashed instance
// share one stimulus stream, and a queue-based scoreboard holds the expected fields.

module tb_l1_addr_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] addr;
  logic        is_ba;
  logic        out_ready;

  logic        in_ready_d, out_valid_d, same_d;
  logic [24:0] tag_d;
  logic [4:0]  set_d;
  logic [1:0]  off_d;
  logic        in_ready_h, out_valid_h, same_h;
  logic [24:0] tag_h;
  logic [4:0]  set_h;
  logic [1:0]  off_h;

  always #5 clk = ~clk;

  l1_addr_decode_pipe #(.SET_HASH(0)) u_dir (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_d),
    .addr_i(addr), .addr_is_ba_i(is_ba), .out_valid_o(out_valid_d), .out_ready_i(out_ready),
    .tag_o(tag_d), .set_o(set_d), .off_o(off_d), .same_set_o(same_d)
  );

  l1_addr_decode_pipe #(.SET_HASH(1)) u_hash (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_h),
    .addr_i(addr), .addr_is_ba_i(is_ba), .out_valid_o(out_valid_h), .out_ready_i(out_ready),
    .tag_o(tag_h), .set_o(set_h), .off_o(off_h), .same_set_o(same_h)
  );

  typedef struct {
    logic [31:0] tag;
    logic [4:0]  set_d;
    logic [4:0]  set_h;
    logic [1:0]  off;
    logic        same_d;
    logic        same_h;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       hv_d, hv_h;
  logic [4:0] hs_d, hs_h;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode written with shifts and masks.
  function automatic exp_t model(input logic [31:0] a, input logic ba);
    exp_t e;
    logic [31:0] t, s;
    if (ba) begin
      e.off = 2'd0;
      s = a & 32'h1F;
      t = (a & 32'h3FFF_FFFF) >> 5;
    end else begin
      e.off = 2'(a & 32'h3);
      s = (a >> 2) & 32'h1F;
      t = a >> 7;
    end
    e.tag    = t;
    e.set_d  = 5'(s);
    e.set_h  = 5'(s ^ (t & 32'h1F));
    e.same_d = 1'b0;
    e.same_h = 1'b0;
    return e;
  endfunction

  // Scoreboard: at each falling edge, check occupancy, then account for the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      hv_d = 1'b0;
      hv_h = 1'b0;
    end else begin
      check_eq("out_valid_d", 32'(out_valid_d), 32'(q.size() != 0));
      check_eq("out_valid_h", 32'(out_valid_h), 32'(q.size() != 0));
      check_eq("in_ready_d",  32'(in_ready_d),  32'(q.size() != 2));
      check_eq("in_ready_h",  32'(in_ready_h),  32'(q.size() != 2));
      if (flush) begin
        q.delete();
        hv_d = 1'b0;
        hv_h = 1'b0;
      end else begin
        if (out_valid_d && out_ready && q.size() != 0) begin
          e = q.pop_front();
          check_eq("tag_d",  32'(tag_d),  e.tag);
          check_eq("tag_h",  32'(tag_h),  e.tag);
          check_eq("set_d",  32'(set_d),  32'(e.set_d));
          check_eq("set_h",  32'(set_h),  32'(e.set_h));
          check_eq("off_d",  32'(off_d),  32'(e.off));
          check_eq("off_h",  32'(off_h),  32'(e.off));
          check_eq("same_d", 32'(same_d), 32'(e.same_d));
          check_eq("same_h", 32'(same_h), 32'(e.same_h));
        end
        if (in_valid && in_ready_d) begin
          e = model(addr, is_ba);
          e.same_d = hv_d && (e.set_d == hs_d);
          e.same_h = hv_h && (e.set_h == hs_h);
          hv_d = 1'b1;
          hs_d = e.set_d;
          hv_h = 1'b1;
          hs_h = e.set_h;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic ba);
    logic acc;
    addr     = a;
    is_ba    = ba;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = in_ready_d;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check_eq("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    logic done;
    done      = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!out_valid_d) done = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (!done) check_eq("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; addr = '0; is_ba = 1'b0; out_ready = 1'b0;
    hv_d = 1'b0; hv_h = 1'b0; hs_d = '0; hs_h = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid_d), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready_d),  32'd1);
    check_eq("rst_tag",       32'(tag_d),       32'd0);
    check_eq("rst_set",       32'(set_h),       32'd0);
    check_eq("rst_same",      32'(same_d),      32'd0);
    rst = 1'b0;

    // T1: full-mode decode of 0xF4
    send(32'h0000_00F4, 1'b0);
    @(negedge clk);
    check_eq("t1_tag",    32'(tag_d),  32'h1);
    check_eq("t1_set",    32'(set_d),  32'h1D);
    check_eq("t1_off",    32'(off_d),  32'h0);
    check_eq("t1_same",   32'(same_d), 32'h0);
    check_eq("t1_set_hash", 32'(set_h), 32'h1C);
    drain();

    // T2: 0xF5 lands in the same hashed set as 0xF4
    send(32'h0000_00F5, 1'b0);
    @(negedge clk);
    check_eq("t2_set_hash",  32'(set_h),  32'h1C);
    check_eq("t2_off",       32'(off_h),  32'h1);
    check_eq("t2_same_hash", 32'(same_h), 32'h1);
    drain();

    // T3: block-address mode
    send(32'h0000_0123, 1'b1);
    @(negedge clk);
    check_eq("t3_tag", 32'(tag_d), 32'h9);
    check_eq("t3_set", 32'(set_d), 32'h03);
    check_eq("t3_off", 32'(off_d), 32'h0);
    drain();

    // T4: buffer fills at two entries; the third request waits for a pop
    send(32'h0000_1000, 1'b0);
    send(32'h0000_2004, 1'b0);
    addr = 32'h0000_3008; is_ba = 1'b0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t4_full_ready", 32'(in_ready_d),  32'd0);
    check_eq("t4_full_valid", 32'(out_valid_d), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("t4_ready_back", 32'(in_ready_d), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // T5: steady push+pop with one entry resident
    send(32'h0000_0080, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr = 32'h0000_0100 + 32'(i * 4) + 32'(i % 4);
      @(negedge clk);
      check_eq("t5_valid", 32'(out_valid_d), 32'd1);
      check_eq("t5_ready", 32'(in_ready_d),  32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    drain();

    // T6: flush of a full buffer beats a same-cycle push and clears the history
    send(32'h0000_0040, 1'b0);
    send(32'h0000_0044, 1'b0);
    flush = 1'b1; in_valid = 1'b1; addr = 32'h0000_0048;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_valid", 32'(out_valid_d), 32'd0);
    check_eq("t6_ready", 32'(in_ready_d),  32'd1);
    check_eq("t6_tag",   32'(tag_d),       32'd0);
    check_eq("t6_set",   32'(set_h),       32'd0);
    send(32'h0000_0044, 1'b0);
    @(negedge clk);
    check_eq("t6_same_d", 32'(same_d), 32'd0);
    check_eq("t6_same_h", 32'(same_h), 32'd0);
    drain();

    // Random traffic with set collisions, both modes and occasional flushes
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 24) == 0);
      is_ba     = 1'($urandom_range(0, 1));
      addr      = 32'($urandom_range(0, 3) * 128 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) addr = addr | ($urandom & 32'hFFFF_0000);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    drain();

    // T7: reset in the middle of a transfer
    send(32'h0000_0500, 1'b0);
    send(32'h0000_0604, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t7_valid_now", 32'(out_valid_d), 32'd0);
    check_eq("t7_tag_now",   32'(tag_d),       32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t7_ready", 32'(in_ready_d),  32'd1);
    check_eq("t7_valid", 32'(out_valid_h), 32'd0);
    send(32'h0000_0604, 1'b0);
    @(negedge clk);
    check_eq("t7_same", 32'(same_d), 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
